// File: rtl/univ_shift_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : univ_shift_pkg                                               |
// | Description : Shared definitions for the universal shift register:         |
// |               operation-select encodings and the shift-counter width       |
// |               helper (CW = max(1, clog2(WIDTH))).                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package univ_shift_pkg;

  // Operation select carried on the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Width of the shift counter. Never below one bit, so a 2-bit register
  // still has a counter that can hold 0..1.
  function automatic int calc_cw(input int width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage : univ_shift_pkg
`default_nettype wire

// File: rtl/univ_shift_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : univ_shift_reg_if                                            |
// | Description : Control and data bundle of the universal shift register.     |
// |               master modport: the agent driving mode/serial/parallel data  |
// |               slave  modport: the register itself                          |
// | Signals     : mode[1:0]      operation select (hold/shr/shl/load)           |
// |               sin_r          serial bit entering the MSB on shift right     |
// |               sin_l          serial bit entering the LSB on shift left      |
// |               pdata[W-1:0]   parallel load data                             |
// |               rot            rotate select (UNIV_SHIFT_ROTATE_EN only)      |
// |               q, qbar        register contents and its complement           |
// |               sout_r, sout_l serial taps q[0] and q[WIDTH-1]                |
// |               shift_cnt      shifts since last load/clear/wrap              |
// |               wrap           one-cycle pulse after WIDTH shifts             |
// | Macro       : UNIV_SHIFT_ROTATE_EN adds the rot signal.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface univ_shift_reg_if
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
);

  localparam int CW = calc_cw(WIDTH);

  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pdata;
`ifdef UNIV_SHIFT_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    shift_cnt;
  logic             wrap;

  modport master (
    output mode,
    output sin_r,
    output sin_l,
    output pdata,
`ifdef UNIV_SHIFT_ROTATE_EN
    output rot,
`endif
    input  q,
    input  qbar,
    input  sout_r,
    input  sout_l,
    input  shift_cnt,
    input  wrap
  );

  modport slave (
    input  mode,
    input  sin_r,
    input  sin_l,
    input  pdata,
`ifdef UNIV_SHIFT_ROTATE_EN
    input  rot,
`endif
    output q,
    output qbar,
    output sout_r,
    output sout_l,
    output shift_cnt,
    output wrap
  );

endinterface : univ_shift_reg_if
`default_nettype wire

// File: rtl/univ_shift_reg_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : univ_shift_cnt                                               |
// | Description : Shift counter and wrap pulse. Counts shift operations from   |
// |               0 to WIDTH-1; the shift taken at WIDTH-1 returns the count   |
// |               to 0 and raises wrap for exactly one clock cycle.            |
// |               State changes on the falling clock edge.                     |
// | Ports       : clk      clock (falling-edge active)                          |
// |               clr_n    asynchronous active-low clear                        |
// |               inc      a shift happens at this edge                         |
// |               clr_cnt  a parallel load happens at this edge                 |
// |               cnt      current shift count (CW bits)                        |
// |               wrap     registered one-cycle wrap pulse                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module univ_shift_cnt
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW   = calc_cw(WIDTH)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          inc,
  input  logic          clr_cnt,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap_q;
  logic          wrap_d;

  // wrap defaults low so it can only ever last a single cycle; hold and
  // load both leave it cleared.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;

endmodule : univ_shift_cnt
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : univ_shift_reg                                               |
// | Description : Universal shift register with hold, shift right, shift left  |
// |               and parallel load, plus a shift counter with wrap pulse.     |
// |               All state changes happen on the falling edge of clk;         |
// |               clr_n clears everything asynchronously.                      |
// | Parameters  : WIDTH  register width, legal range 2..64 (default 8)          |
// | Ports       : clk    clock (falling-edge active)                            |
// |               clr_n  asynchronous active-low clear                          |
// |               bus    univ_shift_reg_if slave modport: mode, sin_r, sin_l,   |
// |                      pdata, [rot] in; q, qbar, sout_r, sout_l,              |
// |                      shift_cnt, wrap out                                    |
// | Macro       : UNIV_SHIFT_ROTATE_EN - when defined, bus.rot=1 makes shifts  |
// |               rotate (the bit leaving one end re-enters at the other)      |
// |               instead of taking sin_r/sin_l.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  univ_shift_reg_if.slave bus
);

  mode_e            mode_sel;
  logic             fill_r;     // bit entering the MSB on shift right
  logic             fill_l;     // bit entering the LSB on shift left
  logic             do_shift;
  logic             do_load;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign mode_sel = mode_e'(bus.mode);

`ifdef UNIV_SHIFT_ROTATE_EN
  assign fill_r = bus.rot ? q_q[0]       : bus.sin_r;
  assign fill_l = bus.rot ? q_q[WIDTH-1] : bus.sin_l;
`else
  assign fill_r = bus.sin_r;
  assign fill_l = bus.sin_l;
`endif

  always_comb begin
    q_d      = q_q;
    do_shift = 1'b0;
    do_load  = 1'b0;
    case (mode_sel)
      MODE_SHR: begin
        q_d      = {fill_r, q_q[WIDTH-1:1]};
        do_shift = 1'b1;
      end
      MODE_SHL: begin
        q_d      = {q_q[WIDTH-2:0], fill_l};
        do_shift = 1'b1;
      end
      MODE_LOAD: begin
        q_d     = bus.pdata;
        do_load = 1'b1;
      end
      default: begin
        q_d = q_q;
      end
    endcase
  end

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Both shift directions feed the same counter, so a direction change
  // mid-sequence keeps counting.
  univ_shift_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk     (clk),
    .clr_n   (clr_n),
    .inc     (do_shift),
    .clr_cnt (do_load),
    .cnt     (bus.shift_cnt),
    .wrap    (bus.wrap)
  );

  // Pure combinational taps of the register: qbar follows the async clear
  // with no extra latency.
  assign bus.q      = q_q;
  assign bus.qbar   = ~q_q;
  assign bus.sout_r = q_q[0];
  assign bus.sout_l = q_q[WIDTH-1];

endmodule : univ_shift_reg
`default_nettype wire
